// File: rtl/lsu_pkg.sv
// Shared encodings and alignment helper for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        LDR  = 3'd2,
        MRG  = 3'd3,
        WR   = 3'd4
    } state_e;

    // Reserved size is rejected the same way as a misaligned access.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad_s;
        case (size)
            SZ_BYTE: bad_s = 1'b0;
            SZ_HALF: bad_s = offset[0];
            SZ_WORD: bad_s = (offset != 2'b00);
            default: bad_s = 1'b1;
        endcase
        return bad_s;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: load extract/extend and sub-word store merge (little-endian).
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        zext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [31:0] shifted_s;
    logic [31:0] mask_s;
    logic [31:0] insert_s;
    logic [4:0]  shamt_s;

    // Select and extend the addressed lane of the fetched word.
    always_comb begin
        shamt_s   = {offset, 3'b000};
        shifted_s = word >> shamt_s;
        case (size)
            SZ_BYTE: load_data = zext ? {24'h000000, shifted_s[7:0]}
                                      : {{24{shifted_s[7]}}, shifted_s[7:0]};
            SZ_HALF: load_data = zext ? {16'h0000, shifted_s[15:0]}
                                      : {{16{shifted_s[15]}}, shifted_s[15:0]};
            default: load_data = word;
        endcase
    end

    // Replace only the addressed lane(s) of the old word with store data.
    always_comb begin
        case (size)
            SZ_BYTE: begin
                mask_s   = 32'h0000_00FF << shamt_s;
                insert_s = {24'h000000, wdata[7:0]} << shamt_s;
            end
            SZ_HALF: begin
                mask_s   = 32'h0000_FFFF << shamt_s;
                insert_s = {16'h0000, wdata[15:0]} << shamt_s;
            end
            default: begin
                mask_s   = 32'hFFFF_FFFF;
                insert_s = wdata;
            end
        endcase
        merge_data = (word & ~mask_s) | (insert_s & mask_s);
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store front end driving a word-only datamemory;
// sub-word stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_dataIn,
    input  logic [31:0]       mem_dataOut
);

    state_e              state_r;
    logic                we_r;
    logic [1:0]          size_r;
    logic                zext_r;
    logic [1:0]          offset_r;
    logic [ADDR_W-1:0]   waddr_r;
    logic [31:0]         wdata_r;
    logic                done_r;
    logic                err_r;
    logic [31:0]         rdata_r;

    logic [31:0]         load_data_s;
    logic [31:0]         merge_data_s;
    logic                mem_cs_s;
    logic                mem_we_s;
    logic [31:0]         mem_dataIn_s;
    logic                unused_addr_s;

    assign unused_addr_s = ^req_addr[31:ADDR_W+2];

    lsu_lane_align u_align (
        .word       (mem_dataOut),
        .offset     (offset_r),
        .size       (size_r),
        .zext       (zext_r),
        .wdata      (wdata_r),
        .load_data  (load_data_s),
        .merge_data (merge_data_s)
    );

    // Control FSM with registered completion status and load result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            we_r     <= 1'b0;
            size_r   <= SZ_BYTE;
            zext_r   <= 1'b0;
            offset_r <= 2'b00;
            waddr_r  <= '0;
            wdata_r  <= 32'h0000_0000;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            rdata_r  <= 32'h0000_0000;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        we_r     <= req_we;
                        size_r   <= req_size;
                        zext_r   <= req_unsigned;
                        offset_r <= req_addr[1:0];
                        waddr_r  <= req_addr[ADDR_W+1:2];
                        wdata_r  <= req_wdata;
                        if (misaligned(req_size, req_addr[1:0])) begin
                            done_r  <= 1'b1;
                            err_r   <= 1'b1;
                            state_r <= IDLE;
                        end else if (req_we && (req_size == SZ_WORD)) begin
                            state_r <= WR;
                        end else begin
                            state_r <= RD;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD:      state_r <= we_r ? MRG : LDR;
                LDR: begin
                    rdata_r <= load_data_s;
                    done_r  <= 1'b1;
                    state_r <= IDLE;
                end
                MRG, WR: begin
                    done_r  <= 1'b1;
                    state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Memory strobes follow the current state; MRG merges the word read in RD.
    always_comb begin
        mem_cs_s     = 1'b0;
        mem_we_s     = 1'b0;
        mem_dataIn_s = wdata_r;
        case (state_r)
            RD:  mem_cs_s = 1'b1;
            MRG: begin
                mem_cs_s     = 1'b1;
                mem_we_s     = 1'b1;
                mem_dataIn_s = merge_data_s;
            end
            WR: begin
                mem_cs_s = 1'b1;
                mem_we_s = 1'b1;
            end
            default: begin
                mem_cs_s = 1'b0;
                mem_we_s = 1'b0;
            end
        endcase
    end

    assign req_ready  = (state_r == IDLE);
    assign mem_cs     = mem_cs_s & ~rst;
    assign mem_we     = mem_we_s & ~rst;
    assign mem_addr   = waddr_r;
    assign mem_dataIn = mem_dataIn_s;
    assign done       = done_r;
    assign err        = err_r;
    assign rdata      = rdata_r;

endmodule
